// File: rtl/ex_div_pkg.sv
// Shared types and widths for the EX-stage iterative divider.
package ex_div_pkg;

  localparam int unsigned XLEN       = 32;
  localparam int unsigned CNT_W      = 5;
  localparam int unsigned REG_ADDR_W = 5;

  typedef enum logic [1:0] {
    DIV_OP_DIV  = 2'b00,
    DIV_OP_DIVU = 2'b01,
    DIV_OP_REM  = 2'b10,
    DIV_OP_REMU = 2'b11
  } div_op_e;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_CALC = 2'd1,
    DIV_DONE = 2'd2
  } div_state_e;

  // Two's-complement negate when neg is set.
  function automatic logic [XLEN-1:0] neg_if(input logic [XLEN-1:0] v, input logic neg);
    return neg ? (~v + XLEN'(1)) : v;
  endfunction

endpackage

// File: rtl/ex_div_if.sv
// EX-stage divide request / result bundle between the pipeline and the divider.
interface ex_div_if;
  import ex_div_pkg::*;

  logic                  start_i;
  logic [1:0]            op_i;
  logic [XLEN-1:0]       dividend_i;
  logic [XLEN-1:0]       divisor_i;
  logic [REG_ADDR_W-1:0] rd_addr_i;
  logic                  flush_i;
  logic                  busy_o;
  logic                  ready_o;
  logic [XLEN-1:0]       result_o;
  logic [REG_ADDR_W-1:0] rd_addr_o;
  logic                  regs_wen_o;

  modport master (
    output start_i, op_i, dividend_i, divisor_i, rd_addr_i, flush_i,
    input  busy_o, ready_o, result_o, rd_addr_o, regs_wen_o
  );

  modport slave (
    input  start_i, op_i, dividend_i, divisor_i, rd_addr_i, flush_i,
    output busy_o, ready_o, result_o, rd_addr_o, regs_wen_o
  );

endinterface

// File: rtl/ex_div.sv
// Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU in EX.
module ex_div
  import ex_div_pkg::*;
(
  input  logic     clk,
  input  logic     rstn,
  ex_div_if.slave  bus
);

  div_state_e            state_q;
  logic [CNT_W-1:0]      cnt_q;
  logic [1:0]            op_q;
  logic                  dvd_neg_q;
  logic                  dvs_neg_q;
  logic [XLEN-1:0]       divisor_q;
  logic [XLEN-1:0]       rem_q;
  logic [XLEN-1:0]       quot_q;
  logic [REG_ADDR_W-1:0] rd_q;
  logic                  ready_q;
  logic [XLEN-1:0]       result_q;
  logic [REG_ADDR_W-1:0] rd_out_q;

  logic            accept_c;
  logic            signed_op_c;
  logic            dvd_neg_c;
  logic            dvs_neg_c;
  logic            div_zero_c;
  logic            ovf_c;
  logic [XLEN-1:0] special_c;
  logic [XLEN:0]   shifted_c;
  logic [XLEN:0]   diff_c;
  logic [XLEN-1:0] rem_nxt_c;
  logic [XLEN-1:0] quot_nxt_c;
  logic [XLEN-1:0] final_c;

  // Request decode: acceptance, signedness and the two short-circuit cases.
  always_comb begin
    accept_c    = (state_q == DIV_IDLE) & bus.start_i & ~bus.flush_i;
    signed_op_c = ~bus.op_i[0];
    dvd_neg_c   = signed_op_c & bus.dividend_i[XLEN-1];
    dvs_neg_c   = signed_op_c & bus.divisor_i[XLEN-1];
    div_zero_c  = (bus.divisor_i == '0);
    ovf_c       = signed_op_c
                & (bus.dividend_i == {1'b1, {(XLEN-1){1'b0}}})
                & (bus.divisor_i == '1);
    special_c   = '0;
    if (div_zero_c) begin
      special_c = bus.op_i[1] ? bus.dividend_i : '1;
    end else if (ovf_c) begin
      special_c = bus.op_i[1] ? '0 : bus.dividend_i;
    end
  end

  // One restoring step plus sign correction of the resulting quotient/remainder.
  always_comb begin
    shifted_c = {rem_q, quot_q[XLEN-1]};
    diff_c    = shifted_c - {1'b0, divisor_q};
    if (!diff_c[XLEN]) begin
      rem_nxt_c  = diff_c[XLEN-1:0];
      quot_nxt_c = {quot_q[XLEN-2:0], 1'b1};
    end else begin
      rem_nxt_c  = shifted_c[XLEN-1:0];
      quot_nxt_c = {quot_q[XLEN-2:0], 1'b0};
    end
    if (op_q[1]) begin
      final_c = neg_if(rem_nxt_c, (op_q == DIV_OP_REM) & dvd_neg_q);
    end else begin
      final_c = neg_if(quot_nxt_c, (op_q == DIV_OP_DIV) & (dvd_neg_q ^ dvs_neg_q));
    end
  end

  // Control FSM with operand datapath and registered result outputs.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= DIV_IDLE;
      cnt_q     <= '0;
      op_q      <= '0;
      dvd_neg_q <= 1'b0;
      dvs_neg_q <= 1'b0;
      divisor_q <= '0;
      rem_q     <= '0;
      quot_q    <= '0;
      rd_q      <= '0;
      ready_q   <= 1'b0;
      result_q  <= '0;
      rd_out_q  <= '0;
    end else begin
      ready_q  <= 1'b0;
      result_q <= '0;
      rd_out_q <= '0;
      unique case (state_q)
        DIV_IDLE: begin
          if (accept_c) begin
            op_q      <= bus.op_i;
            rd_q      <= bus.rd_addr_i;
            dvd_neg_q <= dvd_neg_c;
            dvs_neg_q <= dvs_neg_c;
            divisor_q <= neg_if(bus.divisor_i, dvs_neg_c);
            quot_q    <= neg_if(bus.dividend_i, dvd_neg_c);
            rem_q     <= '0;
            cnt_q     <= '0;
            if (div_zero_c | ovf_c) begin
              state_q  <= DIV_DONE;
              ready_q  <= 1'b1;
              result_q <= special_c;
              rd_out_q <= bus.rd_addr_i;
            end else begin
              state_q <= DIV_CALC;
            end
          end
        end
        DIV_CALC: begin
          if (bus.flush_i) begin
            state_q <= DIV_IDLE;
          end else begin
            rem_q  <= rem_nxt_c;
            quot_q <= quot_nxt_c;
            cnt_q  <= cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(XLEN-1)) begin
              state_q  <= DIV_DONE;
              ready_q  <= 1'b1;
              result_q <= final_c;
              rd_out_q <= rd_q;
            end
          end
        end
        DIV_DONE: state_q <= DIV_IDLE;
        default:  state_q <= DIV_IDLE;
      endcase
    end
  end

  // Stall request drops in the flush cycle and while the result is presented.
  assign bus.busy_o     = accept_c | ((state_q == DIV_CALC) & ~bus.flush_i);
  assign bus.ready_o    = ready_q;
  assign bus.regs_wen_o = ready_q;
  assign bus.result_o   = result_q;
  assign bus.rd_addr_o  = rd_out_q;

endmodule
